imm_extend_pipe: RTL and testbench

//  Registered, multi-lane successor of the combinational immediate extender. Per beat it accepts LANES raw
//  32-bit instructions and, for each lane, decodes the immediate type from the opcode and emits the

---
 rtl/riscv_pkg.sv | 58 +++++
 rtl/imm_extend_unit.sv | 23 ++
 rtl/imm_extend_pipe.sv | 153 +++++++++++++++
 tb/tb_imm_extend_pipe.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V immediate definitions: type enum, opcode
// decode and immediate extension helpers.
package riscv_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5,
        IMM_Z    = 3'd6
    } immediate_type_e;

    localparam int IMM_TYPE_W = $bits(immediate_type_e);

    // SYSTEM with funct3[2] set carries a 5-bit zimm in rs1.
    function automatic immediate_type_e get_imm_type(
        input logic [6:0] opcode,
        input logic [2:0] funct3,
        input logic       zimm_en
    );
        immediate_type_e t;
        case (opcode)
            7'b0110111,
            7'b0010111: t = IMM_U;
            7'b1101111: t = IMM_J;
            7'b1100111,
            7'b0000011,
            7'b0010011: t = IMM_I;
            7'b0100011: t = IMM_S;
            7'b1100011: t = IMM_B;
            7'b1110011: t = (zimm_en && funct3[2]) ? IMM_Z : IMM_I;
            default:    t = IMM_NONE;
        endcase
        return t;
    endfunction

    function automatic logic [XLEN-1:0] imm_extend(
        input immediate_type_e t,
        input logic [31:0]     i
    );
        logic [XLEN-1:0] r;
        case (t)
            IMM_I:   r = {{20{i[31]}}, i[31:20]};
            IMM_S:   r = {{20{i[31]}}, i[31:25], i[11:7]};
            IMM_B:   r = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            IMM_U:   r = {i[31:12], 12'b0};
            IMM_J:   r = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            IMM_Z:   r = {27'b0, i[19:15]};
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/imm_extend_unit.sv
// Per-lane immediate extender; an absent lane yields
// type NONE and a zero immediate.
module imm_extend_unit
    import riscv_pkg::*;
(
    input  logic            lane_valid_i,
    input  logic [31:7]     instr_i,
    input  immediate_type_e type_i,
    output immediate_type_e type_o,
    output logic [XLEN-1:0] imm_o
);

    // Opcode bits are not needed once the type is known.
    always_comb begin
        type_o = IMM_NONE;
        imm_o  = '0;
        if (lane_valid_i) begin
            type_o = type_i;
            imm_o  = imm_extend(type_i, {instr_i, 7'b0});
        end
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// Registered multi-lane immediate extender with a one-beat
// skid buffer behind the output stage.
module imm_extend_pipe
    import riscv_pkg::*;
#(
    parameter int LANES   = 2,
    parameter bit ZIMM_EN = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [LANES-1:0]            in_lane_valid,
    input  logic [LANES*32-1:0]         in_instr,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [LANES-1:0]            out_lane_valid,
    output logic [LANES*32-1:0]         out_instr,
    output logic [LANES*IMM_TYPE_W-1:0] out_imm_type,
    output logic [LANES*XLEN-1:0]       out_imm
);

    localparam int TW = LANES * IMM_TYPE_W;
    localparam int IW = LANES * XLEN;
    localparam int DW = LANES * 32;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_ONE,
        ST_FULL
    } occ_e;

    occ_e             state_q;
    logic             out_valid_q;
    logic             in_ready_q;
    logic [LANES-1:0] out_lv_q;
    logic [DW-1:0]    out_instr_q;
    logic [TW-1:0]    out_type_q;
    logic [IW-1:0]    out_imm_q;
    logic [LANES-1:0] skid_lv_q;
    logic [DW-1:0]    skid_instr_q;
    logic [TW-1:0]    skid_type_q;
    logic [IW-1:0]    skid_imm_q;

    logic [TW-1:0]    type_d;
    logic [IW-1:0]    imm_d;
    logic             accept;
    logic             push;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        immediate_type_e dec_type;
        immediate_type_e ext_type;
        logic [XLEN-1:0] ext_imm;

        assign dec_type = get_imm_type(in_instr[32*g +: 7],
                                       in_instr[32*g+12 +: 3],
                                       ZIMM_EN);

        imm_extend_unit u_ext (
            .lane_valid_i (in_lane_valid[g]),
            .instr_i      (in_instr[32*g+7 +: 25]),
            .type_i       (dec_type),
            .type_o       (ext_type),
            .imm_o        (ext_imm)
        );

        assign type_d[IMM_TYPE_W*g +: IMM_TYPE_W] = ext_type;
        assign imm_d[XLEN*g +: XLEN]              = ext_imm;
    end

    assign accept = in_valid & in_ready_q;
    assign push   = out_valid_q & out_ready;

    // Occupancy FSM moving beats between input, skid and output regs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_EMPTY;
            out_valid_q  <= 1'b0;
            in_ready_q   <= 1'b1;
            out_lv_q     <= '0;
            out_instr_q  <= '0;
            out_type_q   <= '0;
            out_imm_q    <= '0;
            skid_lv_q    <= '0;
            skid_instr_q <= '0;
            skid_type_q  <= '0;
            skid_imm_q   <= '0;
        end else if (flush) begin
            state_q      <= ST_EMPTY;
            out_valid_q  <= 1'b0;
            in_ready_q   <= 1'b1;
            skid_lv_q    <= '0;
            skid_instr_q <= '0;
            skid_type_q  <= '0;
            skid_imm_q   <= '0;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        out_lv_q    <= in_lane_valid;
                        out_instr_q <= in_instr;
                        out_type_q  <= type_d;
                        out_imm_q   <= imm_d;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && push) begin
                        out_lv_q    <= in_lane_valid;
                        out_instr_q <= in_instr;
                        out_type_q  <= type_d;
                        out_imm_q   <= imm_d;
                    end else if (push) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_EMPTY;
                    end else if (accept) begin
                        skid_lv_q    <= in_lane_valid;
                        skid_instr_q <= in_instr;
                        skid_type_q  <= type_d;
                        skid_imm_q   <= imm_d;
                        in_ready_q   <= 1'b0;
                        state_q      <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (push) begin
                        out_lv_q    <= skid_lv_q;
                        out_instr_q <= skid_instr_q;
                        out_type_q  <= skid_type_q;
                        out_imm_q   <= skid_imm_q;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_ONE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= ST_EMPTY;
                end
            endcase
        end
    end

    assign in_ready       = in_ready_q;
    assign out_valid      = out_valid_q;
    assign out_lane_valid = out_lv_q;
    assign out_instr      = out_instr_q;
    assign out_imm_type   = out_type_q;
    assign out_imm        = out_imm_q;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Bench for imm_extend_pipe: directed vector table, handshake
// corner sequences and a randomized scoreboard run.
module tb_imm_extend_pipe;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [1:0]  in_lane_valid;
    logic [63:0] in_instr;

    logic        in_ready, out_valid;
    logic [1:0]  out_lane_valid;
    logic [63:0] out_instr, out_imm;
    logic [5:0]  out_imm_type;

    logic        in_ready0, out_valid0;
    logic [1:0]  out_lane_valid0;
    logic [63:0] out_instr0, out_imm0;
    logic [5:0]  out_imm_type0;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    imm_extend_pipe #(.LANES(2), .ZIMM_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_lane_valid(in_lane_valid), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_lane_valid(out_lane_valid), .out_instr(out_instr),
        .out_imm_type(out_imm_type), .out_imm(out_imm)
    );

    imm_extend_pipe #(.LANES(2), .ZIMM_EN(1'b0)) dut0 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready0),
        .in_lane_valid(in_lane_valid), .in_instr(in_instr),
        .out_valid(out_valid0), .out_ready(out_ready),
        .out_lane_valid(out_lane_valid0), .out_instr(out_instr0),
        .out_imm_type(out_imm_type0), .out_imm(out_imm0)
    );

    typedef struct {
        logic [1:0]  lv;
        logic [63:0] instr;
        logic [63:0] imm;
        logic [5:0]  typ;
    } beat_t;

    typedef struct {
        logic [1:0]  lv;
        logic [63:0] instr;
        logic [63:0] imm1;
        logic [5:0]  typ1;
        logic [63:0] imm0;
        logic [5:0]  typ0;
    } vec_t;

    beat_t sb_q[$];

    // Reference decode straight from the opcode table.
    function automatic logic [2:0] ref_type(input logic [31:0] x, input bit z);
        case (x[6:0])
            7'h37, 7'h17:        return IMM_U;
            7'h6F:               return IMM_J;
            7'h67, 7'h03, 7'h13: return IMM_I;
            7'h23:               return IMM_S;
            7'h63:               return IMM_B;
            7'h73:               return (z && x[14]) ? IMM_Z : IMM_I;
            default:             return IMM_NONE;
        endcase
    endfunction

    // Reference immediate built with shifts and ORs of the fields.
    function automatic logic [31:0] ref_imm(input logic [31:0] x, input bit z);
        logic [31:0] sg;
        sg = {32{x[31]}};
        case (ref_type(x, z))
            IMM_I: return (sg << 12) | 32'(x[31:20]);
            IMM_S: return (sg << 12) | (32'(x[31:25]) << 5) | 32'(x[11:7]);
            IMM_B: return (sg << 12) | (32'(x[7]) << 11)
                          | (32'(x[30:25]) << 5) | (32'(x[11:8]) << 1);
            IMM_U: return x & 32'hFFFF_F000;
            IMM_J: return (sg << 20) | (32'(x[19:12]) << 12)
                          | (32'(x[20]) << 11) | (32'(x[30:21]) << 1);
            IMM_Z: return 32'(x[19:15]);
            default: return 32'h0;
        endcase
    endfunction

    function automatic beat_t model(input logic [1:0] lv, input logic [63:0] ins, input bit z);
        beat_t b;
        logic [31:0] x;
        b.lv    = lv;
        b.instr = ins;
        b.imm   = '0;
        b.typ   = '0;
        for (int k = 0; k < 2; k++) begin
            x = ins[32*k +: 32];
            if (lv[k]) begin
                b.imm[32*k +: 32] = ref_imm(x, z);
                b.typ[3*k +: 3]   = ref_type(x, z);
            end
        end
        return b;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: pop on output handshake, push model beat on input handshake.
    always @(negedge clk) begin
        beat_t e;
        if (!rst) begin
            if (flush) begin
                sb_q.delete();
            end else begin
                if (out_valid && out_ready) begin
                    if (sb_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL sb_extra: got beat imm %h expected no beat", out_imm);
                    end else begin
                        e = sb_q.pop_front();
                        chk("sb_imm", out_imm, e.imm);
                        chk("sb_type", 64'(out_imm_type), 64'(e.typ));
                        chk("sb_lv", 64'(out_lane_valid), 64'(e.lv));
                        chk("sb_instr", out_instr, e.instr);
                    end
                end
                if (in_valid && in_ready)
                    sb_q.push_back(model(in_lane_valid, in_instr, 1'b1));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] lv, input logic [63:0] ins);
        in_valid      = 1'b1;
        in_lane_valid = lv;
        in_instr      = ins;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not reach summary");
        $fatal(1);
    end

    initial begin
        vec_t  tbl[8];
        beat_t ba, bb, bc, be;
        logic [6:0]  ops[10];
        logic [31:0] r0, r1;
        int          guard;

        tbl[0] = '{2'b11, {32'h7FF08193, 32'h10000097},
                   {32'h000007FF, 32'h10000000}, {IMM_I, IMM_U},
                   {32'h000007FF, 32'h10000000}, {IMM_I, IMM_U}};
        tbl[1] = '{2'b11, {32'h01188863, 32'hFEB52E23},
                   {32'h00000010, 32'hFFFFFFFC}, {IMM_B, IMM_S},
                   {32'h00000010, 32'hFFFFFFFC}, {IMM_B, IMM_S}};
        tbl[2] = '{2'b11, {32'h010588B3, 32'h3007D073},
                   {32'h00000000, 32'h0000000F}, {IMM_NONE, IMM_Z},
                   {32'h00000000, 32'h00000300}, {IMM_NONE, IMM_I}};
        tbl[3] = '{2'b10, {32'h01C0006F, 32'h01C0006F},
                   {32'h0000001C, 32'h00000000}, {IMM_J, IMM_NONE},
                   {32'h0000001C, 32'h00000000}, {IMM_J, IMM_NONE}};
        tbl[4] = '{2'b01, {32'hFFFFFFFF, 32'h80000537},
                   {32'h00000000, 32'h80000000}, {IMM_NONE, IMM_U},
                   {32'h00000000, 32'h80000000}, {IMM_NONE, IMM_U}};
        tbl[5] = '{2'b11, {32'hFE000EE3, 32'hFFC08067},
                   {32'hFFFFFFFC, 32'hFFFFFFFC}, {IMM_B, IMM_I},
                   {32'hFFFFFFFC, 32'hFFFFFFFC}, {IMM_B, IMM_I}};
        tbl[6] = '{2'b11, {32'h80002003, 32'h8000006F},
                   {32'hFFFFF800, 32'hFFF00000}, {IMM_I, IMM_J},
                   {32'hFFFFF800, 32'hFFF00000}, {IMM_I, IMM_J}};
        tbl[7] = '{2'b11, {32'h34011073, 32'h00112623},
                   {32'h00000340, 32'h0000000C}, {IMM_I, IMM_S},
                   {32'h00000340, 32'h0000000C}, {IMM_I, IMM_S}};

        ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03,
                7'h13, 7'h23, 7'h63, 7'h73, 7'h33};

        rst       = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b1;
        drive(2'b11, {32'h7FF08193, 32'h10000097});

        // Reset held with a valid beat offered.
        repeat (3) begin
            step();
            chk("rst_out_valid", 64'(out_valid), 64'd0);
        end
        chk("rst_out_imm", out_imm, 64'd0);
        chk("rst_out_type", 64'(out_imm_type), 64'd0);
        rst      = 1'b0;
        in_valid = 1'b0;
        step();
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);
        chk("post_rst_in_ready0", 64'(in_ready0), 64'd1);
        chk("post_rst_out_valid", 64'(out_valid), 64'd0);

        // Directed decode table, one beat each with out_ready=1.
        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].lv, tbl[i].instr);
            step();
            in_valid = 1'b0;
            chk($sformatf("tbl%0d_valid", i), 64'(out_valid), 64'd1);
            chk($sformatf("tbl%0d_imm", i), out_imm, tbl[i].imm1);
            chk($sformatf("tbl%0d_type", i), 64'(out_imm_type), 64'(tbl[i].typ1));
            chk($sformatf("tbl%0d_lv", i), 64'(out_lane_valid), 64'(tbl[i].lv));
            chk($sformatf("tbl%0d_imm_z0", i), out_imm0, tbl[i].imm0);
            chk($sformatf("tbl%0d_type_z0", i), 64'(out_imm_type0), 64'(tbl[i].typ0));
            chk($sformatf("tbl%0d_misc_z0", i),
                {out_instr0[61:0], out_lane_valid0}, {tbl[i].instr[61:0], tbl[i].lv});
        end
        step();
        chk("idle_out_valid", 64'(out_valid), 64'd0);

        // Backpressure: three back-to-back beats with out_ready low.
        ba = model(2'b11, {32'hFFF00013, 32'h00001037}, 1'b1);
        bb = model(2'b11, {32'h00A12023, 32'h0080006F}, 1'b1);
        bc = model(2'b01, {32'h00000000, 32'h0002C073}, 1'b1);
        out_ready = 1'b0;
        drive(ba.lv, ba.instr);
        step();
        chk("bp_a_valid", 64'(out_valid), 64'd1);
        drive(bb.lv, bb.instr);
        step();
        chk("bp_full_in_ready", 64'(in_ready), 64'd0);
        chk("bp_hold_a_imm", out_imm, ba.imm);
        drive(bc.lv, bc.instr);
        step();
        chk("bp_c_blocked", 64'(in_ready), 64'd0);
        chk("bp_stable_imm", out_imm, ba.imm);
        chk("bp_stable_type", 64'(out_imm_type), 64'(ba.typ));
        out_ready = 1'b1;
        step();
        chk("bp_rel_b_imm", out_imm, bb.imm);
        chk("bp_rel_in_ready", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        chk("bp_rel_c_imm", out_imm, bc.imm);
        chk("bp_rel_c_type", 64'(out_imm_type), 64'(bc.typ));
        step();
        chk("bp_drained", 64'(out_valid), 64'd0);

        // Flush while FULL; a beat offered with flush is dropped.
        out_ready = 1'b0;
        drive(ba.lv, ba.instr);
        step();
        drive(bb.lv, bb.instr);
        step();
        chk("fl_full", 64'(in_ready), 64'd0);
        flush = 1'b1;
        drive(bc.lv, bc.instr);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_out_valid", 64'(out_valid), 64'd0);
        chk("fl_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        step();
        chk("fl_no_stale", 64'(out_valid), 64'd0);
        be = model(2'b11, {32'h0000A0B7, 32'hFFF58593}, 1'b1);
        drive(be.lv, be.instr);
        step();
        in_valid = 1'b0;
        chk("fl_new_valid", 64'(out_valid), 64'd1);
        chk("fl_new_imm", out_imm, be.imm);
        step();

        // Randomized traffic with backpressure and occasional flush.
        for (int c = 0; c < 3000; c++) begin
            r0        = $urandom();
            r1        = $urandom();
            r0[6:0]   = ops[$urandom_range(9)];
            r1[6:0]   = ops[$urandom_range(9)];
            in_valid  = ($urandom_range(3) != 0);
            in_lane_valid = 2'($urandom_range(3));
            in_instr  = {r1, r0};
            out_ready = ($urandom_range(9) < 7);
            flush     = ($urandom_range(59) == 0);
            step();
        end
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        guard     = 0;
        while (sb_q.size() != 0 && guard < 20) begin
            step();
            guard++;
        end
        chk("drain_empty", 64'(sb_q.size()), 64'd0);
        step();
        chk("drain_out_valid", 64'(out_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
